// File: rtl/core_pkg.sv
// Shared loader types and default instruction-bus geometry.
package core_pkg;

    localparam int unsigned INSTR_DATA_WIDTH = 32;
    localparam int unsigned INSTR_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Program-word source, core instruction bus and memory port seen by instr_loader.
interface instr_loader_if
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = INSTR_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = INSTR_ADDR_WIDTH
);
    logic                  i_start;
    logic                  i_word_valid;
    logic [DATA_WIDTH-1:0] i_word_data;
    logic                  i_word_last;
    logic                  o_word_ready;
    logic                  i_core_we;
    logic [ADDR_WIDTH-1:0] i_core_addr;
    logic [DATA_WIDTH-1:0] i_core_wdata;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  o_core_rst_n;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_overflow;
    logic [ADDR_WIDTH:0]   o_word_count;

    modport slave (
        input  i_start, i_word_valid, i_word_data, i_word_last,
        input  i_core_we, i_core_addr, i_core_wdata,
        output o_word_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_core_rst_n, o_busy, o_done, o_overflow, o_word_count
    );

    modport master (
        output i_start, i_word_valid, i_word_data, i_word_last,
        output i_core_we, i_core_addr, i_core_wdata,
        input  o_word_ready, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_core_rst_n, o_busy, o_done, o_overflow, o_word_count
    );
endinterface

// File: rtl/instr_loader.sv
// Streams a program into instruction memory, then releases the core and hands
// the memory write port over to the core's instruction bus.
module instr_loader
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = INSTR_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = INSTR_ADDR_WIDTH,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    instr_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LAST_IX = {1'b0, {ADDR_WIDTH{1'b1}}};

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  wr_we_q, wr_we_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = done_q;
        wr_we_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            IDLE, RUN: begin
                if (bus.i_start) begin
                    state_d    = LOAD;
                    addr_d     = BASE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    done_d     = 1'b0;
                end
            end
            LOAD: begin
                // Capture now, write next cycle; the final write lands in FLUSH.
                if (bus.i_word_valid) begin
                    wr_we_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = bus.i_word_data;
                    addr_d    = addr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    if (bus.i_word_last || count_q == LAST_IX) begin
                        state_d    = FLUSH;
                        overflow_d = ~bus.i_word_last;
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d == LOAD) || (state_d == FLUSH);
        core_rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            addr_q       <= BASE;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
            wr_we_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            core_rst_n_q <= core_rst_n_d;
            wr_we_q      <= wr_we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.o_word_ready = (state_q == LOAD);
    assign bus.o_mem_we     = (state_q == RUN) ? bus.i_core_we    : wr_we_q;
    assign bus.o_mem_addr   = (state_q == RUN) ? bus.i_core_addr  : wr_addr_q;
    assign bus.o_mem_wdata  = (state_q == RUN) ? bus.i_core_wdata : wr_data_q;
    assign bus.o_core_rst_n = core_rst_n_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector tables plus a write scoreboard.
module tb_instr_loader;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    typedef struct {
        logic          valid;
        logic          last;
        logic          start;
        logic [DW-1:0] data;
    } ld_vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } bus_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    logic [AW-1:0] exp_addr;
    int   exp_cnt;
    wr_t  sb[$];

    ld_vec_t  load_a[3];
    ld_vec_t  load_b[7];
    bus_vec_t bus_tab[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    instr_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every loader-side write must match the oldest accepted word, one cycle later.
    always @(negedge clk) begin
        if (mon_en && bus.o_mem_we !== 1'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(bus.o_mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(bus.o_mem_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.o_mem_wdata), 64'(e.data));
                chk("wr_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},     64'(bus.o_busy),       64'd0);
        chk({tag, "_done"},     64'(bus.o_done),       64'd0);
        chk({tag, "_core_rst"}, 64'(bus.o_core_rst_n), 64'd0);
        chk({tag, "_mem_we"},   64'(bus.o_mem_we),     64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.o_mem_addr),   64'd0);
        chk({tag, "_mem_data"}, 64'(bus.o_mem_wdata),  64'd0);
        chk({tag, "_count"},    64'(bus.o_word_count), 64'd0);
        chk({tag, "_overflow"}, 64'(bus.o_overflow),   64'd0);
        chk({tag, "_ready"},    64'(bus.o_word_ready), 64'd0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = d;
        bus.i_word_last  = last;
        #1 chk("word_ready", 64'(bus.o_word_ready), 64'd1);
        sb.push_back('{addr: exp_addr, data: d, cyc: cyc + 1});
        exp_addr = exp_addr + 1'b1;
        exp_cnt++;
        @(negedge clk);
        bus.i_word_valid = 1'b0;
        bus.i_word_last  = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        exp_addr = '0;
        exp_cnt  = 0;
        chk("load_busy",  64'(bus.o_busy),       64'd1);
        chk("load_count", 64'(bus.o_word_count), 64'd0);
        chk("load_done",  64'(bus.o_done),       64'd0);
    endtask

    task automatic apply_load(input ld_vec_t v);
        bus.i_start = v.start;
        if (v.valid) begin
            send(v.data, v.last);
        end else begin
            #1 chk("gap_ready", 64'(bus.o_word_ready), 64'd1);
            @(negedge clk);
        end
        bus.i_start = 1'b0;
    endtask

    // Called in the FLUSH cycle that follows the final acceptance.
    task automatic finish_load(input logic exp_ovf);
        chk("flush_busy",  64'(bus.o_busy),       64'd1);
        chk("flush_ready", 64'(bus.o_word_ready), 64'd0);
        chk("flush_done",  64'(bus.o_done),       64'd0);
        @(negedge clk);
        chk("run_done",     64'(bus.o_done),       64'd1);
        chk("run_core_rst", 64'(bus.o_core_rst_n), 64'd1);
        chk("run_busy",     64'(bus.o_busy),       64'd0);
        chk("run_ready",    64'(bus.o_word_ready), 64'd0);
        chk("run_count",    64'(bus.o_word_count), 64'(exp_cnt));
        chk("run_overflow", 64'(bus.o_overflow),   64'(exp_ovf));
        chk("sb_drained",   64'(sb.size()),        64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_start      = 1'b0;
        bus.i_word_valid = 1'b0;
        bus.i_word_data  = '0;
        bus.i_word_last  = 1'b0;
        bus.i_core_we    = 1'b0;
        bus.i_core_addr  = '0;
        bus.i_core_wdata = '0;
        exp_addr = '0;
        exp_cnt  = 0;

        load_a[0] = '{valid: 1'b1, last: 1'b0, start: 1'b0, data: 32'h6800_0000};
        load_a[1] = '{valid: 1'b1, last: 1'b0, start: 1'b0, data: 32'h1111_1111};
        load_a[2] = '{valid: 1'b1, last: 1'b1, start: 1'b0, data: 32'h2222_2222};

        load_b[0] = '{valid: 1'b1, last: 1'b0, start: 1'b0, data: 32'hA000_0001};
        load_b[1] = '{valid: 1'b0, last: 1'b0, start: 1'b0, data: 32'h0};
        load_b[2] = '{valid: 1'b1, last: 1'b0, start: 1'b0, data: 32'hA000_0002};
        load_b[3] = '{valid: 1'b0, last: 1'b0, start: 1'b1, data: 32'h0};
        load_b[4] = '{valid: 1'b1, last: 1'b0, start: 1'b0, data: 32'hA000_0003};
        load_b[5] = '{valid: 1'b0, last: 1'b0, start: 1'b0, data: 32'h0};
        load_b[6] = '{valid: 1'b1, last: 1'b1, start: 1'b0, data: 32'hA000_0004};

        bus_tab[0] = '{we: 1'b1, addr: 8'h10, data: 32'hDEAD_BEEF,
                       exp_we: 1'b1, exp_addr: 8'h10, exp_data: 32'hDEAD_BEEF};
        bus_tab[1] = '{we: 1'b0, addr: 8'hFF, data: 32'h1234_5678,
                       exp_we: 1'b0, exp_addr: 8'hFF, exp_data: 32'h1234_5678};
        bus_tab[2] = '{we: 1'b1, addr: 8'h00, data: 32'hA5A5_5A5A,
                       exp_we: 1'b1, exp_addr: 8'h00, exp_data: 32'hA5A5_5A5A};

        repeat (3) @(negedge clk);
        chk_reset_state("por");
        mon_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk_reset_state("idle");

        // Three-word program, last flagged on the third word.
        pulse_start();
        foreach (load_a[i]) apply_load(load_a[i]);
        finish_load(1'b0);

        // Valid toggling with idle gaps; a start pulse mid-load must be ignored.
        pulse_start();
        foreach (load_b[i]) apply_load(load_b[i]);
        finish_load(1'b0);

        // Two-word program, then exercise the core bus pass-through.
        pulse_start();
        send(32'hC0DE_0000, 1'b0);
        send(32'hC0DE_0001, 1'b1);
        finish_load(1'b0);
        mon_en = 1'b0;
        foreach (bus_tab[i]) begin
            bus.i_core_we    = bus_tab[i].we;
            bus.i_core_addr  = bus_tab[i].addr;
            bus.i_core_wdata = bus_tab[i].data;
            #1;
            chk("run_mem_we",   64'(bus.o_mem_we),    64'(bus_tab[i].exp_we));
            chk("run_mem_addr", 64'(bus.o_mem_addr),  64'(bus_tab[i].exp_addr));
            chk("run_mem_data", 64'(bus.o_mem_wdata), 64'(bus_tab[i].exp_data));
            @(negedge clk);
        end

        // Restart from RUN with a word offered alongside start and the core still writing.
        bus.i_core_we    = 1'b1;
        bus.i_core_addr  = 8'h10;
        bus.i_core_wdata = 32'hDEAD_BEEF;
        bus.i_start      = 1'b1;
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = 32'h0BAD_0BAD;
        #1 chk("run_start_ready", 64'(bus.o_word_ready), 64'd0);
        @(negedge clk);
        bus.i_start      = 1'b0;
        bus.i_word_valid = 1'b0;
        exp_addr = '0;
        exp_cnt  = 0;
        mon_en   = 1'b1;
        chk("restart_core_rst", 64'(bus.o_core_rst_n), 64'd0);
        chk("restart_done",     64'(bus.o_done),       64'd0);
        chk("restart_busy",     64'(bus.o_busy),       64'd1);
        chk("restart_count",    64'(bus.o_word_count), 64'd0);
        chk("restart_mem_we",   64'(bus.o_mem_we),     64'd0);
        bus.i_core_we = 1'b0;

        // Full-capacity load with no last flag: 256 writes, wrap, overflow.
        for (int i = 0; i < 256; i++) send($urandom, 1'b0);
        finish_load(1'b1);

        // Reset arriving while a third word is offered abandons the load.
        pulse_start();
        chk("reload_overflow_clr", 64'(bus.o_overflow), 64'd0);
        send(32'h5555_0000, 1'b0);
        send(32'h5555_0001, 1'b0);
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = 32'h5555_0002;
        rst_n = 1'b0;
        @(negedge clk);
        bus.i_word_valid = 1'b0;
        chk_reset_state("midrst");
        chk("midrst_sb", 64'(sb.size()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send(32'h7777_7777, 1'b1);
        finish_load(1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 8, instruction memory word-address width (depth 2^ADDR_WIDTH = 256).
REQ-003 Parameter BASE_ADDR, default 0, first memory address written by a load.
REQ-004 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_start  in  1  single-cycle pulse; begins a program load.
REQ-007 i_word_valid  in  1  source has a program word on i_word_data.
REQ-008 i_word_data  in  DATA_WIDTH  program word.
REQ-009 i_word_last  in  1  qualifies the final word of the program; sampled with i_word_valid.
REQ-010 o_word_ready  out  1  loader accepts a word this cycle.
REQ-011 i_core_we / i_core_addr / i_core_wdata  in  1 / ADDR_WIDTH / DATA_WIDTH  core instruction-bus request.
REQ-012 o_mem_we / o_mem_addr / o_mem_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  to the instruction memory write/address port.
REQ-013 o_core_rst_n  out  1  active-low reset to the core.
REQ-014 o_busy  out  1  load in progress.
REQ-015 o_done  out  1  last load completed; core running.
REQ-016 o_overflow  out  1  last load hit capacity without i_word_last.
REQ-017 o_word_count  out  ADDR_WIDTH+1  words written by the current or last load.

Function
REQ-018 FSM states: IDLE, LOAD, FLUSH, RUN.
REQ-019 IDLE: o_word_ready=0, o_core_rst_n=0; i_start -> LOAD next cycle.
REQ-020 Entering LOAD: address counter=BASE_ADDR, o_word_count=0, o_overflow=0, o_done=0.
REQ-021 LOAD: o_word_ready=1 combinationally; a word is accepted in any cycle with i_word_valid=1.
REQ-022 Accepted word is written with 1-cycle latency: next cycle o_mem_we=1, o_mem_addr=counter, o_mem_wdata=word; counter and o_word_count then increment by 1.
REQ-023 Counter wraps modulo 2^ADDR_WIDTH; the 2^ADDR_WIDTH-th accepted word ends the load.
REQ-024 LOAD -> FLUSH when the accepted word has i_word_last=1, or is the 2^ADDR_WIDTH-th word (o_overflow=1 if i_word_last=0 on that word).
REQ-025 FLUSH lasts exactly 1 cycle (the final write completes there); o_word_ready=0; FLUSH -> RUN.
REQ-026 RUN: o_core_rst_n=1, o_done=1, o_word_ready=0; o_mem_* drive i_core_* combinationally.
REQ-027 In IDLE, LOAD and FLUSH, o_mem_* are owned by the loader; o_mem_we=0 when no write is pending; i_core_* ignored.
REQ-028 o_busy=1 in LOAD and FLUSH only.
REQ-029 i_start in LOAD or FLUSH: ignored.
REQ-030 i_start in RUN: -> LOAD next cycle, o_core_rst_n=0 in that same cycle, REQ-020 applies; core bus disconnected.
REQ-031 i_start and i_word_valid together in IDLE/RUN: word not accepted (ready=0).
REQ-032 o_word_count, o_overflow hold their values in RUN until next load.

Reset
REQ-033 i_rst_n=0 at a rising edge: state=IDLE, counter=BASE_ADDR, o_word_count=0, o_overflow=0, o_done=0, o_busy=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_core_rst_n=0.
REQ-034 Reset mid-load abandons the load; no write issued in the following cycle.

Structure
REQ-035 Shared package core_pkg holds loader_state_t enum and the default instruction width/address-width constants.
REQ-036 No sub-module; bus mux is inline in instr_loader.

Verification
REQ-037 Reset, start, 3 words 0x68000000/0x11111111/0x22222222, last on 3rd -> writes addr 0,1,2 one cycle after each acceptance; o_word_count=3; o_done=1, o_core_rst_n=1 two cycles after last acceptance.
REQ-038 Load with i_word_valid toggling 1/0 for 4 words -> exactly 4 writes, addresses contiguous 0..3, no write in idle gaps.
REQ-039 256 words, none flagged last -> addresses 0..255, o_overflow=1, o_word_count=256, RUN entered.
REQ-040 In RUN, drive i_core_we=1, addr 0x10, data 0xDEADBEEF -> o_mem_* equal those values same cycle; repeat in LOAD -> o_mem_we=0.
REQ-041 i_start in RUN after a 2-word load -> o_core_rst_n=0 next cycle, o_done=0, new load starts at BASE_ADDR with o_word_count=0.
REQ-042 i_rst_n=0 after 2nd word accepted -> no write next cycle, all outputs at REQ-033 values; fresh start loads from addr 0.
